// File: rtl/lfsr_hit_pkg.sv
// Shared types and helpers for the LFSR window hit counter.
package lfsr_hit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  // Number of samples in one measurement window.
  function automatic int unsigned win_len(input int unsigned win_log2);
    return 32'd1 << win_log2;
  endfunction

endpackage

// File: rtl/hit_accum.sv
// Clear/enable/increment counter used for the per-window hit counts.
// Clear has priority over increment.
module hit_accum #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  // Count register: async reset, synchronous clear, otherwise +1 when enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lfsr_window_hit_counter.sv
// Window hit counter: counts hit_a and hit_a&hit_b over a fixed window of
// 2**WIN_LOG2 accepted samples and presents both counts over valid/ready.
// Optional: define LFSR_HIT_AUTO_RESTART_EN to start the next window
// directly from the result handshake instead of returning to idle.
module lfsr_window_hit_counter
  import lfsr_hit_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             hit_a,
  input  logic             hit_b,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_both
);

  localparam int unsigned WIN_LEN = win_len(WIN_LOG2);
  localparam int unsigned SCNT_W  = WIN_LOG2 + 1;
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(WIN_LEN - 1);

  // A full window of hits must fit in the count outputs.
  if (CNT_W < WIN_LOG2 + 1) begin : gen_bad_cnt_w
    $error("CNT_W must be at least WIN_LOG2+1");
  end

  state_e            state_q;
  logic [SCNT_W-1:0] scnt_q;
  logic              busy_q;
  logic              result_valid_q;

  logic accept;
  logic handshake;
  logic last_sample;
  logic clr_counts;

  // Sample acceptance, window end and count-clear decode.
  always_comb begin
    accept      = (state_q == StAccum) && sample_valid;
    handshake   = (state_q == StHold) && result_ready;
    last_sample = accept && (scnt_q == LAST_SAMPLE);
    clr_counts  = (state_q == StIdle) && start;
`ifdef LFSR_HIT_AUTO_RESTART_EN
    clr_counts  = clr_counts || handshake;
`endif
  end

  // Control FSM with sample counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      scnt_q         <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StAccum;
            scnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        StAccum: begin
          if (accept) begin
            // Counter stops at WIN_LEN because the state leaves ACCUM here.
            scnt_q <= scnt_q + SCNT_W'(1);
          end
          if (last_sample) begin
            state_q        <= StHold;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (handshake) begin
            result_valid_q <= 1'b0;
`ifdef LFSR_HIT_AUTO_RESTART_EN
            state_q        <= StAccum;
            busy_q         <= 1'b1;
            scnt_q         <= '0;
`else
            state_q        <= StIdle;
`endif
          end
        end
        default: begin
          state_q        <= StIdle;
          busy_q         <= 1'b0;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  hit_accum #(
    .Width (CNT_W)
  ) u_count_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (clr_counts),
    .en_i    (accept && hit_a),
    .count_o (count_a)
  );

  hit_accum #(
    .Width (CNT_W)
  ) u_count_both (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (clr_counts),
    .en_i    (accept && hit_a && hit_b),
    .count_o (count_both)
  );

  assign busy         = busy_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_lfsr_window_hit_counter.sv
// Bench for lfsr_window_hit_counter (WIN_LOG2=4, CNT_W=8). Expected counts are
// pushed to a queue as each window's last sample is driven and popped when
// the DUT presents the result. Define LFSR_HIT_AUTO_RESTART_EN to cover the
// auto-restart build.
module tb_lfsr_window_hit_counter;

  localparam int unsigned WIN_LOG2 = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned WIN_LEN  = 16;
`ifdef LFSR_HIT_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct packed {
    logic [CNT_W-1:0] a;
    logic [CNT_W-1:0] both;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sample_valid;
  logic             hit_a;
  logic             hit_b;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_both;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned total;
  int unsigned bad;
  int unsigned m_n;
  int unsigned m_a;
  int unsigned m_both;

  lfsr_window_hit_counter #(
    .WIN_LOG2 (WIN_LOG2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_valid (sample_valid),
    .hit_a        (hit_a),
    .hit_b        (hit_b),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .count_a      (count_a),
    .count_both   (count_both)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_n    = 0;
    m_a    = 0;
    m_both = 0;
  endtask

  task automatic start_window();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic drive_sample(input logic a, input logic b);
    sample_valid = 1'b1;
    hit_a        = a;
    hit_b        = b;
    tick();
    sample_valid = 1'b0;
    hit_a        = 1'b0;
    hit_b        = 1'b0;
    m_n++;
    if (a) m_a++;
    if (a && b) m_both++;
    if (m_n == WIN_LEN) begin
      e.a  = m_a[CNT_W-1:0];
      e.both = m_both[CNT_W-1:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_handshake();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (result_valid !== 1'b0) begin
      bad++; $display("FAIL rst_rv: got %b want 0", result_valid);
    end
    if (count_a !== 8'd0) begin bad++; $display("FAIL rst_ca: got %0d want 0", count_a); end
    if (count_both !== 8'd0) begin
      bad++; $display("FAIL rst_cb: got %0d want 0", count_both);
    end
    rst = 1'b0;
    tick();
    // Mid-stream asynchronous reset, then activity while reset is held.
    start_window();
    for (int i = 0; i < 3; i++) drive_sample(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    if (count_a !== 8'd0) begin bad++; $display("FAIL arst_ca: got %0d want 0", count_a); end
    if (count_both !== 8'd0) begin
      bad++; $display("FAIL arst_cb: got %0d want 0", count_both);
    end
    start        = 1'b1;
    sample_valid = 1'b1;
    hit_a        = 1'b1;
    tick();
    tick();
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy: got %b want 0", busy); end
    if (result_valid !== 1'b0) begin
      bad++; $display("FAIL hold_rv: got %b want 0", result_valid);
    end
    if (count_a !== 8'd0) begin bad++; $display("FAIL hold_ca: got %0d want 0", count_a); end
    start        = 1'b0;
    sample_valid = 1'b0;
    hit_a        = 1'b0;
    rst          = 1'b0;
    tick();
  endtask

  task automatic test_full_hits();
    start_window();
    for (int i = 0; i < 15; i++) drive_sample(1'b1, 1'b1);
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL full_busy15: got %b want 1", busy); end
    if (result_valid !== 1'b0) begin
      bad++; $display("FAIL full_rv15: got %b want 0", result_valid);
    end
    drive_sample(1'b1, 1'b1);
    total += 2;
    if (result_valid !== 1'b1) begin
      bad++; $display("FAIL full_rv: got %b want 1", result_valid);
    end
    if (busy !== 1'b0) begin bad++; $display("FAIL full_busy: got %b want 0", busy); end
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL full_sb: got empty queue want 1 entry");
    end else begin
      e = exp_q.pop_front();
      total += 2;
      if (count_a !== e.a) begin
        bad++; $display("FAIL full_ca: got %0d want %0d", count_a, e.a);
      end
      if (count_both !== e.both) begin
        bad++; $display("FAIL full_cb: got %0d want %0d", count_both, e.both);
      end
    end
    do_handshake();
    total += 2;
    if (result_valid !== 1'b0) begin
      bad++; $display("FAIL full_hs_rv: got %b want 0", result_valid);
    end
    if (busy !== AUTO) begin bad++; $display("FAIL full_hs_busy: got %b want %b", busy, AUTO); end
  endtask

  task automatic test_mixed_gaps();
    for (int run = 0; run < 2; run++) begin
      start_window();
      total++;
      if (count_a !== 8'd0) begin bad++; $display("FAIL mix_clr: got %0d want 0", count_a); end
      for (int i = 0; i < 16; i++) begin
        drive_sample((i % 2) == 0, ((i % 2) == 0) && (run == 0));
        if (i != 15) repeat (3) tick();
      end
      total += 2;
      if (result_valid !== 1'b1) begin
        bad++; $display("FAIL mix_rv: got %b want 1", result_valid);
      end
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL mix_sb: got empty queue want 1 entry");
      end else begin
        e = exp_q.pop_front();
        total += 2;
        if (count_a !== e.a) begin
          bad++; $display("FAIL mix_ca: got %0d want %0d", count_a, e.a);
        end
        if (count_both !== e.both) begin
          bad++; $display("FAIL mix_cb: got %0d want %0d", count_both, e.both);
        end
      end
      do_handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] after_a;
    logic [CNT_W-1:0] after_b;
    start_window();
    for (int i = 0; i < 16; i++) drive_sample(1'b1, 1'b0);
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL bp_sb: got empty queue want 1 entry");
    end else begin
      e = exp_q.pop_front();
      sample_valid = 1'b1;
      hit_a        = 1'b1;
      hit_b        = 1'b1;
      for (int i = 0; i < 5; i++) begin
        start = (i % 2) == 0;
        tick();
        total += 4;
        if (result_valid !== 1'b1) begin
          bad++; $display("FAIL bp_rv: got %b want 1", result_valid);
        end
        if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy: got %b want 0", busy); end
        if (count_a !== e.a) begin
          bad++; $display("FAIL bp_ca: got %0d want %0d", count_a, e.a);
        end
        if (count_both !== e.both) begin
          bad++; $display("FAIL bp_cb: got %0d want %0d", count_both, e.both);
        end
      end
      sample_valid = 1'b0;
      hit_a        = 1'b0;
      hit_b        = 1'b0;
      // Start coincides with the handshake and must not begin a window.
      start        = 1'b1;
      result_ready = 1'b1;
      tick();
      start        = 1'b0;
      result_ready = 1'b0;
      after_a = AUTO ? 8'd0 : e.a;
      after_b = AUTO ? 8'd0 : e.both;
      total += 4;
      if (result_valid !== 1'b0) begin
        bad++; $display("FAIL bp_hs_rv: got %b want 0", result_valid);
      end
      if (busy !== AUTO) begin bad++; $display("FAIL bp_hs_busy: got %b want %b", busy, AUTO); end
      if (count_a !== after_a) begin
        bad++; $display("FAIL bp_hs_ca: got %0d want %0d", count_a, after_a);
      end
      if (count_both !== after_b) begin
        bad++; $display("FAIL bp_hs_cb: got %0d want %0d", count_both, after_b);
      end
      tick();
      total++;
      if (busy !== AUTO) begin bad++; $display("FAIL bp_post_busy: got %b want %b", busy, AUTO); end
    end
  endtask

  task automatic test_reset_mid_window();
    start_window();
    for (int i = 0; i < 7; i++) drive_sample(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (result_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rv: got %b want 0", result_valid);
    end
    if (count_a !== 8'd0) begin bad++; $display("FAIL mid_ca: got %0d want 0", count_a); end
    if (count_both !== 8'd0) begin
      bad++; $display("FAIL mid_cb: got %0d want 0", count_both);
    end
    tick();
    rst = 1'b0;
    tick();
    start_window();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_restart_busy: got %b want 1", busy); end
    for (int i = 0; i < 16; i++) drive_sample(1'b1, 1'b0);
    total += 2;
    if (result_valid !== 1'b1) begin
      bad++; $display("FAIL mid_rv2: got %b want 1", result_valid);
    end
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL mid_sb: got empty queue want 1 entry");
    end else begin
      e = exp_q.pop_front();
      total += 2;
      if (count_a !== e.a) begin
        bad++; $display("FAIL mid_ca2: got %0d want %0d", count_a, e.a);
      end
      if (count_both !== e.both) begin
        bad++; $display("FAIL mid_cb2: got %0d want %0d", count_both, e.both);
      end
    end
    do_handshake();
  endtask

`ifdef LFSR_HIT_AUTO_RESTART_EN
  task automatic test_auto_restart();
    start_window();
    for (int i = 0; i < 16; i++) drive_sample(1'b1, 1'b1);
    void'(exp_q.pop_front());
    // Sample offered in the handshake cycle must not be counted.
    sample_valid = 1'b1;
    hit_a        = 1'b1;
    hit_b        = 1'b1;
    do_handshake();
    sample_valid = 1'b0;
    hit_a        = 1'b0;
    hit_b        = 1'b0;
    model_clear();
    total += 4;
    if (busy !== 1'b1) begin bad++; $display("FAIL auto_busy: got %b want 1", busy); end
    if (result_valid !== 1'b0) begin
      bad++; $display("FAIL auto_rv0: got %b want 0", result_valid);
    end
    if (count_a !== 8'd0) begin bad++; $display("FAIL auto_ca0: got %0d want 0", count_a); end
    if (count_both !== 8'd0) begin
      bad++; $display("FAIL auto_cb0: got %0d want 0", count_both);
    end
    for (int i = 0; i < 16; i++) drive_sample(1'b0, 1'b1);
    total += 2;
    if (result_valid !== 1'b1) begin
      bad++; $display("FAIL auto_rv: got %b want 1", result_valid);
    end
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL auto_sb: got empty queue want 1 entry");
    end else begin
      e = exp_q.pop_front();
      total += 2;
      if (count_a !== e.a) begin
        bad++; $display("FAIL auto_ca: got %0d want %0d", count_a, e.a);
      end
      if (count_both !== e.both) begin
        bad++; $display("FAIL auto_cb: got %0d want %0d", count_both, e.both);
      end
    end
    do_handshake();
  endtask
`endif

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b0;
    start        = 1'b0;
    sample_valid = 1'b0;
    hit_a        = 1'b0;
    hit_b        = 1'b0;
    result_ready = 1'b0;
    model_clear();
    test_reset();
    test_full_hits();
    test_mixed_gaps();
    test_backpressure();
    test_reset_mid_window();
`ifdef LFSR_HIT_AUTO_RESTART_EN
    test_auto_restart();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
